// File: rtl/game_control_pkg.sv
// ----------------------------------------------------------------------------
// game_control_pkg : state encodings, timeout codes and strobe bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package game_control_pkg;

  typedef enum logic [3:0] {
    S_INIT          = 4'd0,
    S_IDLE          = 4'd1,
    S_GEN_MOVE      = 4'd2,
    S_CHECK_COLLIDE = 4'd3,
    S_APPLY_LINK    = 4'd4,
    S_MOVE_ENEMIES  = 4'd5,
    S_DRAW_MAP      = 4'd6,
    S_DRAW_LINK     = 4'd7,
    S_DRAW_ENEMIES  = 4'd8
  } state_e;

  localparam logic [1:0] TO_NONE    = 2'b00;
  localparam logic [1:0] TO_MAP     = 2'b01;
  localparam logic [1:0] TO_LINK    = 2'b10;
  localparam logic [1:0] TO_ENEMIES = 2'b11;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef struct packed {
    logic init;
    logic idle;
    logic gen_move;
    logic check_collide;
    logic apply_act_link;
    logic move_enemies;
    logic draw_map;
    logic draw_link;
    logic draw_enemies;
  } strobes_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_control_wait_counter.sv
// ----------------------------------------------------------------------------
// game_control_wait_counter : clearable up-counter with terminal-count compare
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module game_control_wait_counter #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] terminal_i,
  output logic             terminal_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    count_q <= count_d;
  end

  assign terminal_o = (count_q == terminal_i);

endmodule

`default_nettype wire

// File: rtl/game_control.sv
// ----------------------------------------------------------------------------
// game_control : per-frame sequencing FSM with draw watchdog and frame counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module game_control
  import game_control_pkg::*;
#(
  parameter int unsigned INIT_CYCLES    = 4,
  parameter int unsigned COLLIDE_CYCLES = 2,
  parameter int unsigned DRAW_TIMEOUT   = 20'hFFFFF,
  parameter int unsigned FRAME_W        = 16
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               idle_done_i,
  input  logic               draw_map_done_i,
  input  logic               draw_link_done_i,
  input  logic               draw_enemies_done_i,
  output logic               init_o,
  output logic               idle_o,
  output logic               gen_move_o,
  output logic               check_collide_o,
  output logic               apply_act_link_o,
  output logic               move_enemies_o,
  output logic               draw_map_o,
  output logic               draw_link_o,
  output logic               draw_enemies_o,
  output logic [FRAME_W-1:0] frame_count_o,
  output logic               timeout_err_o,
  output logic [1:0]         timeout_state_o
);

  localparam int unsigned MAX_HOLD = max3(INIT_CYCLES, COLLIDE_CYCLES, DRAW_TIMEOUT);
  localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1);

  localparam logic [CNT_W-1:0] INIT_TC    = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] COLLIDE_TC = CNT_W'(COLLIDE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAW_TC    = CNT_W'(DRAW_TIMEOUT - 1);

  state_e             state_q;
  state_e             state_d;
  logic [FRAME_W-1:0] frame_count_q;
  logic [FRAME_W-1:0] frame_count_d;
  logic               timeout_err_q;
  logic               timeout_err_d;
  logic [1:0]         timeout_state_q;
  logic [1:0]         timeout_state_d;

  logic [CNT_W-1:0]   cnt_terminal;
  logic               cnt_enable;
  logic               cnt_clear;
  logic               cnt_tc;
  logic               timeout_hit;
  logic [1:0]         timeout_code;
  strobes_t           strobes;

  // One counter serves every timed state; its terminal value follows the state.
  always_comb begin
    cnt_terminal = DRAW_TC;
    cnt_enable   = OFF;
    case (state_q)
      S_INIT:          begin cnt_terminal = INIT_TC;    cnt_enable = ON; end
      S_CHECK_COLLIDE: begin cnt_terminal = COLLIDE_TC; cnt_enable = ON; end
      S_DRAW_MAP,
      S_DRAW_LINK,
      S_DRAW_ENEMIES:  begin cnt_terminal = DRAW_TC;    cnt_enable = ON; end
      default:         begin cnt_terminal = DRAW_TC;    cnt_enable = OFF; end
    endcase
  end

  assign cnt_clear = !resetn_i || (state_d != state_q);

  game_control_wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_counter (
    .clock_i    (clock_i),
    .clear_i    (cnt_clear),
    .enable_i   (cnt_enable),
    .terminal_i (cnt_terminal),
    .terminal_o (cnt_tc)
  );

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // A done on the same edge as the watchdog terminal count takes priority.
  always_comb begin
    state_d      = state_q;
    timeout_hit  = OFF;
    timeout_code = TO_NONE;
    case (state_q)
      S_INIT:          if (cnt_tc) state_d = S_DRAW_MAP;
      S_DRAW_MAP: begin
        if (draw_map_done_i) begin
          state_d = S_DRAW_LINK;
        end else if (cnt_tc) begin
          state_d      = S_DRAW_LINK;
          timeout_hit  = ON;
          timeout_code = TO_MAP;
        end
      end
      S_DRAW_LINK: begin
        if (draw_link_done_i) begin
          state_d = S_DRAW_ENEMIES;
        end else if (cnt_tc) begin
          state_d      = S_DRAW_ENEMIES;
          timeout_hit  = ON;
          timeout_code = TO_LINK;
        end
      end
      S_DRAW_ENEMIES: begin
        if (draw_enemies_done_i) begin
          state_d = S_IDLE;
        end else if (cnt_tc) begin
          state_d      = S_IDLE;
          timeout_hit  = ON;
          timeout_code = TO_ENEMIES;
        end
      end
      S_IDLE:          if (idle_done_i) state_d = S_GEN_MOVE;
      S_GEN_MOVE:      state_d = S_CHECK_COLLIDE;
      S_CHECK_COLLIDE: if (cnt_tc) state_d = S_APPLY_LINK;
      S_APPLY_LINK:    state_d = S_MOVE_ENEMIES;
      S_MOVE_ENEMIES:  state_d = S_DRAW_MAP;
      default:         state_d = S_INIT;
    endcase
  end

  always_comb begin
    frame_count_d   = frame_count_q;
    timeout_err_d   = timeout_err_q;
    timeout_state_d = timeout_state_q;
    if ((state_q == S_DRAW_ENEMIES) && (state_d == S_IDLE)) begin
      frame_count_d = frame_count_q + 1'b1;
    end
    if (timeout_hit) begin
      timeout_err_d   = ON;
      timeout_state_d = timeout_code;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      frame_count_q   <= '0;
      timeout_err_q   <= OFF;
      timeout_state_q <= TO_NONE;
    end else begin
      frame_count_q   <= frame_count_d;
      timeout_err_q   <= timeout_err_d;
      timeout_state_q <= timeout_state_d;
    end
  end

  always_comb begin
    strobes = '0;
    case (state_q)
      S_INIT:          strobes.init           = ON;
      S_IDLE:          strobes.idle           = ON;
      S_GEN_MOVE:      strobes.gen_move       = ON;
      S_CHECK_COLLIDE: strobes.check_collide  = ON;
      S_APPLY_LINK:    strobes.apply_act_link = ON;
      S_MOVE_ENEMIES:  strobes.move_enemies   = ON;
      S_DRAW_MAP:      strobes.draw_map       = ON;
      S_DRAW_LINK:     strobes.draw_link      = ON;
      S_DRAW_ENEMIES:  strobes.draw_enemies   = ON;
      default:         strobes.init           = ON;
    endcase
  end

  assign init_o           = strobes.init;
  assign idle_o           = strobes.idle;
  assign gen_move_o       = strobes.gen_move;
  assign check_collide_o  = strobes.check_collide;
  assign apply_act_link_o = strobes.apply_act_link;
  assign move_enemies_o   = strobes.move_enemies;
  assign draw_map_o       = strobes.draw_map;
  assign draw_link_o      = strobes.draw_link;
  assign draw_enemies_o   = strobes.draw_enemies;
  assign frame_count_o    = frame_count_q;
  assign timeout_err_o    = timeout_err_q;
  assign timeout_state_o  = timeout_state_q;

endmodule

`default_nettype wire

// File: tb/tb_game_control.sv
// ----------------------------------------------------------------------------
// tb_game_control : scripted per-cycle scoreboard for game_control
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_game_control;

  localparam int FW = 4;

  localparam logic [3:0] D_NONE = 4'b0000;
  localparam logic [3:0] D_IDLE = 4'b0001;
  localparam logic [3:0] D_MAP  = 4'b0010;
  localparam logic [3:0] D_LINK = 4'b0100;
  localparam logic [3:0] D_EN   = 4'b1000;

  localparam logic [8:0] B_INIT  = 9'b100000000;
  localparam logic [8:0] B_IDLE  = 9'b010000000;
  localparam logic [8:0] B_GEN   = 9'b001000000;
  localparam logic [8:0] B_COL   = 9'b000100000;
  localparam logic [8:0] B_APPLY = 9'b000010000;
  localparam logic [8:0] B_MOVE  = 9'b000001000;
  localparam logic [8:0] B_MAP   = 9'b000000100;
  localparam logic [8:0] B_LINK  = 9'b000000010;
  localparam logic [8:0] B_EN    = 9'b000000001;

  logic          clock  = 1'b0;
  logic          resetn = 1'b0;
  logic [3:0]    din    = 4'b0000;
  logic          init, idle, gen_move, check_collide, apply_act_link;
  logic          move_enemies, draw_map, draw_link, draw_enemies;
  logic [FW-1:0] frame_count;
  logic          timeout_err;
  logic [1:0]    timeout_state;

  typedef struct {
    string      tag;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t      sb_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic          stim_done = 1'b0;
  logic [FW-1:0] exp_fc  = '0;
  logic          exp_err = 1'b0;
  logic [1:0]    exp_ts  = 2'b00;
  logic [8:0]    obs_st;

  always #5 clock = ~clock;

  game_control #(
    .INIT_CYCLES    (4),
    .COLLIDE_CYCLES (2),
    .DRAW_TIMEOUT   (16),
    .FRAME_W        (FW)
  ) dut (
    .clock_i             (clock),
    .resetn_i            (resetn),
    .idle_done_i         (din[0]),
    .draw_map_done_i     (din[1]),
    .draw_link_done_i    (din[2]),
    .draw_enemies_done_i (din[3]),
    .init_o              (init),
    .idle_o              (idle),
    .gen_move_o          (gen_move),
    .check_collide_o     (check_collide),
    .apply_act_link_o    (apply_act_link),
    .move_enemies_o      (move_enemies),
    .draw_map_o          (draw_map),
    .draw_link_o         (draw_link),
    .draw_enemies_o      (draw_enemies),
    .frame_count_o       (frame_count),
    .timeout_err_o       (timeout_err),
    .timeout_state_o     (timeout_state)
  );

  assign obs_st = {init, idle, gen_move, check_collide, apply_act_link,
                   move_enemies, draw_map, draw_link, draw_enemies};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Each cycle: drive inputs for the next edge and queue the outputs expected now.
  task automatic seg(input string tag, input logic [8:0] st, input int n,
                     input logic [3:0] d_last, input logic [3:0] d_rest, input logic rn);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      resetn = rn;
      din    = (i == n - 1) ? d_last : d_rest;
      sb_q.push_back('{tag: tag, exp: {exp_ts, exp_err, exp_fc, st}});
    end
  endtask

  task automatic tail(input string tag);
    seg({tag, "_gen"},   B_GEN,   1, D_NONE, D_NONE, 1'b1);
    seg({tag, "_col"},   B_COL,   2, D_NONE, D_NONE, 1'b1);
    seg({tag, "_apply"}, B_APPLY, 1, D_NONE, D_NONE, 1'b1);
    seg({tag, "_move"},  B_MOVE,  1, D_NONE, D_NONE, 1'b1);
  endtask

  task automatic quick_frame(input string tag);
    seg({tag, "_map"},  B_MAP,  1, D_MAP, D_NONE, 1'b1);
    seg({tag, "_link"}, B_LINK, 1, D_LINK, D_NONE, 1'b1);
    seg({tag, "_en"},   B_EN,   1, D_EN, D_NONE, 1'b1);
    exp_fc = exp_fc + 1'b1;
    seg({tag, "_idle"}, B_IDLE, 1, D_IDLE, D_NONE, 1'b1);
    tail(tag);
  endtask

  always @(negedge clock) begin
    sb_item_t it;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      chk({it.tag, "_onehot"}, 32'($countones(obs_st)), 32'd1);
      chk(it.tag, {16'd0, timeout_state, timeout_err, frame_count, obs_st}, {16'd0, it.exp});
    end else if (stim_done) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset held, then INIT hold count
    seg("rst",  B_INIT, 3, D_NONE, D_NONE, 1'b0);
    seg("init", B_INIT, 4, D_NONE, D_NONE, 1'b1);

    // full frame, dones five cycles after entry, idle after 100
    seg("t2_map",  B_MAP,  6, D_MAP,  D_NONE, 1'b1);
    seg("t2_link", B_LINK, 6, D_LINK, D_NONE, 1'b1);
    seg("t2_en",   B_EN,   6, D_EN,   D_NONE, 1'b1);
    exp_fc = exp_fc + 1'b1;
    seg("t2_idle", B_IDLE, 101, D_IDLE, D_NONE, 1'b1);
    tail("t2");

    // link watchdog expiry, sticky error
    seg("t3_map",  B_MAP,  3,  D_MAP,  D_NONE, 1'b1);
    seg("t3_link", B_LINK, 16, D_NONE, D_NONE, 1'b1);
    exp_err = 1'b1;
    exp_ts  = 2'b10;
    seg("t3_en",   B_EN,   2, D_EN,   D_NONE, 1'b1);
    exp_fc = exp_fc + 1'b1;
    seg("t3_idle", B_IDLE, 3, D_IDLE, D_NONE, 1'b1);
    tail("t3");

    // done high in entry cycle; stray idle_done during link ignored
    seg("t4_map",  B_MAP,  1, D_MAP,          D_MAP,          1'b1);
    seg("t4_link", B_LINK, 4, D_LINK | D_MAP, D_IDLE | D_MAP, 1'b1);
    seg("t4_en",   B_EN,   1, D_EN,           D_NONE,         1'b1);
    exp_fc = exp_fc + 1'b1;
    seg("t4_idle", B_IDLE, 5, D_IDLE, D_NONE, 1'b1);

    // one-cycle reset in the middle of check_collide
    seg("t5_gen", B_GEN, 1, D_NONE, D_NONE, 1'b1);
    seg("t5_col", B_COL, 1, D_NONE, D_NONE, 1'b0);
    exp_fc  = '0;
    exp_err = 1'b0;
    exp_ts  = 2'b00;
    seg("t5_init", B_INIT, 4, D_NONE, D_NONE, 1'b1);

    // done coinciding with the terminal count wins, then wrap the frame counter
    seg("t6_map16", B_MAP,  16, D_MAP,  D_NONE, 1'b1);
    seg("t6_link",  B_LINK, 1,  D_LINK, D_NONE, 1'b1);
    seg("t6_en",    B_EN,   1,  D_EN,   D_NONE, 1'b1);
    exp_fc = exp_fc + 1'b1;
    seg("t6_idle",  B_IDLE, 1,  D_IDLE, D_NONE, 1'b1);
    tail("t6");
    for (int f = 0; f < 16; f++) begin
      quick_frame($sformatf("t6_f%0d", f + 2));
    end

    // enemies watchdog expiry still counts the frame
    seg("t7_map",  B_MAP,  1,  D_MAP,  D_NONE, 1'b1);
    seg("t7_link", B_LINK, 1,  D_LINK, D_NONE, 1'b1);
    seg("t7_en",   B_EN,   16, D_NONE, D_NONE, 1'b1);
    exp_err = 1'b1;
    exp_ts  = 2'b11;
    exp_fc  = exp_fc + 1'b1;
    seg("t7_idle", B_IDLE, 2, D_NONE, D_NONE, 1'b1);
    stim_done = 1'b1;
  end

endmodule

`default_nettype wire
